vga_capture: RTL and testbench
==============================

Name: vga_capture

Overview:
Receiver for the 29-bit packed VGA video bus produced by the team's VGA output block. It recovers the pixel strobe from bit 28, tracks the active-video region from the blank and sync bits, and emits per-pixel (x, y, r, g, b) with a valid strobe once it has locked to standard 640x480 timing. It sits between a video source, or loopback of the VGA output bus, and a framebuffer writer or checker. It also reports measured line/frame totals and flags timing errors.

Parameters:
H_ACTIVE, 640, required active pixels per line
V_ACTIVE, 480, required active lines per frame
LOCK_FRAMES, 2, consecutive good frames needed to assert locked
TIMEOUT, 255, clk cycles without a pixel strobe before lock is dropped

Ports:
clk  input  1  system clock (50 MHz); single clock domain
rst  input  1  asynchronous, active-low reset
vga_input_data  input  29  [23:0]={b,g,r}, [24]=hsync_n, [25]=vsync_n, [26]=blank_n (1=active), [27]=sync_n (ignored), [28]=pixel clock
r, g, b  output  8 each  captured pixel colour
x, y  output  10 each  captured pixel coordinate
pixel_valid  output  1  one-clk pulse per captured active pixel
frame_start  output  1  one-clk pulse with pixel (0,0)
locked  output  1  level; timing locked
line_error  output  1  one-clk pulse on a timing violation while locked
h_total  output  10  pixel strobes between the last two hsync_n falling edges
v_total  output  10  hsync_n falling edges between the last two vsync_n falling edges

Behaviour:
- Reset (rst=0, async): every output is 0. FSM=SEARCH. All counters and pipeline registers are 0.
- Input stage: vga_input_data is registered every clk into in_q, with a second stage in_q2.
- Pixel strobe: stb = in_q[28] & ~in_q2[28]. All other bus bits are taken from in_q in the stb cycle. No other logic advances without stb.
- Edges are evaluated at stb against the previous strobe's sampled value:
  - hfall: hsync_n 1->0
  - vfall: vsync_n 1->0
  - lend: blank_n 1->0
- Counters (10-bit, saturating at 1023; none wrap):
  - xcnt increments on each stb with blank_n=1; cleared at lend.
  - ycnt increments at lend; cleared at vfall.
  - hcnt increments every stb. At hfall, h_total<=hcnt+1 and hcnt<=0.
  - vcnt increments at hfall. At vfall, v_total<=vcnt and vcnt<=0.
- Line check at lend: the line is good iff xcnt==H_ACTIVE. Frame check at vfall: the frame is good iff ycnt==V_ACTIVE and every line in it was good. The first partial frame after entering SYNCING is not judged.
- FSM:
  - SEARCH: vfall -> SYNCING with good_cnt=0.
  - SYNCING: at vfall, a good frame increments good_cnt and a bad frame sets good_cnt=0. good_cnt==LOCK_FRAMES -> LOCKED; locked=1 from the next clk.
  - LOCKED: a bad line (at lend) or bad frame (at vfall) pulses line_error for 1 clk and goes to SEARCH; locked=0 the next clk.
  - Any state: TIMEOUT clks without stb -> SEARCH, with no line_error pulse.
- Output: on stb with blank_n=1, xcnt<H_ACTIVE, ycnt<V_ACTIVE and state LOCKED:
  - register x=xcnt, y=ycnt, r=[7:0], g=[15:8], b=[23:16], and pulse pixel_valid.
  - Latency: pixel_valid is high exactly 2 clks after the clk edge that first samples vga_input_data[28] high.
  - Pixels with xcnt>=H_ACTIVE are not emitted; the line fails its check at lend.
- r, g, b, x, y hold their last value between pulses.
- frame_start=pixel_valid & x==0 & y==0.
- Simultaneous lend and vfall in one stb: process lend (line check, ycnt++) first, then vfall (frame check, ycnt<=0).
- Reset mid-operation clears everything immediately. Relock requires the full SEARCH->SYNCING->LOCKED sequence.

Test Plan:
1. Hold rst=0, toggle inputs -> all outputs 0. Release rst -> locked stays 0 until vfall sequence.
2. Drive 800x525 timing (hsync_n low strobes 656-751, vsync_n low lines 490-491, blank_n high for x<640, y<480), bit 28 toggling every clk -> locked rises 1 clk after the 3rd vfall; h_total=800, v_total=525.
3. Locked, source r=x[7:0], g=y[7:0], b=8'hA5 -> exactly 307200 pixel_valid per frame. Pixel (5,7) reads r=5, g=7, b=A5. One frame_start per frame, coincident with (0,0).
4. Locked, shorten line y=100 to 639 active pixels -> one line_error pulse at that lend; locked=0 next clk; no pixel_valid until relock 3 vfalls later.
5. Locked, freeze bit 28 for 300 clks -> locked falls 255 clks after the last stb, no line_error; resuming timing relocks after 3 vfalls.
6. Assert rst mid-line while locked -> all outputs 0 in the same cycle. After release, h_total/v_total are 0 until the first hfall/vfall.

Source files
------------

// File: rtl/vga_capture.sv
// Receiver for the packed 29-bit VGA bus: recovers the pixel strobe, verifies
// line/frame timing over consecutive frames, and emits pixels once locked.
module vga_capture #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [28:0] vga_input_data,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        pixel_valid,
    output logic        frame_start,
    output logic        locked,
    output logic        line_error,
    output logic [9:0]  h_total,
    output logic [9:0]  v_total
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT = 10'(V_ACTIVE);

    typedef enum logic [1:0] {SEARCH, SYNCING, LOCKED} state_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pix_t;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    // Input stage; only the strobe bit needs a second register.
    logic [28:0] in_q;
    logic        in_q2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_q  <= '0;
            in_q2 <= 1'b0;
        end else begin
            in_q  <= vga_input_data;
            in_q2 <= in_q[28];
        end
    end

    logic stb, hs_n, vs_n, bl_n;
    logic unused_sync;

    assign stb  = in_q[28] & ~in_q2;
    assign hs_n = in_q[24];
    assign vs_n = in_q[25];
    assign bl_n = in_q[26];
    // Composite sync carries nothing the receiver needs.
    assign unused_sync = in_q[27];

    logic hs_p, vs_p, bl_p;
    logic hfall, vfall, lend;

    assign hfall = stb & hs_p & ~hs_n;
    assign vfall = stb & vs_p & ~vs_n;
    assign lend  = stb & bl_p & ~bl_n;

    logic [9:0]    xcnt, ycnt, hcnt, vcnt;
    logic          frame_bad;
    logic [GW-1:0] good_cnt, good_nx, good_inc;
    logic [TW-1:0] tcnt;
    state_t        state, state_nx;
    logic          err_nx;

    logic       line_bad, frame_good, timeout, emit;
    logic [9:0] ycnt_l;

    // Line check precedes frame check when both edges land on one strobe.
    always_comb begin
        line_bad   = lend && (xcnt != H_ACT);
        ycnt_l     = lend ? sat_inc(ycnt) : ycnt;
        frame_good = (ycnt_l == V_ACT) && !frame_bad && !line_bad;
        timeout    = !stb && (tcnt == TW'(TIMEOUT - 1));
        emit       = stb && bl_n && (xcnt < H_ACT) && (ycnt < V_ACT) && (state == LOCKED);
        good_inc   = good_cnt + GW'(1);
    end

    always_comb begin
        state_nx = state;
        good_nx  = good_cnt;
        err_nx   = 1'b0;
        if (timeout) begin
            state_nx = SEARCH;
        end else begin
            case (state)
                SEARCH: begin
                    if (vfall) begin
                        state_nx = SYNCING;
                        good_nx  = '0;
                    end
                end
                SYNCING: begin
                    if (vfall) begin
                        good_nx = frame_good ? good_inc : '0;
                        if (frame_good && good_inc == GW'(LOCK_FRAMES))
                            state_nx = LOCKED;
                    end
                end
                LOCKED: begin
                    if (line_bad || (vfall && !frame_good)) begin
                        err_nx   = 1'b1;
                        state_nx = SEARCH;
                    end
                end
                default: state_nx = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= SEARCH;
            good_cnt   <= '0;
            line_error <= 1'b0;
        end else begin
            state      <= state_nx;
            good_cnt   <= good_nx;
            line_error <= err_nx;
        end
    end

    assign locked = (state == LOCKED);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            tcnt <= '0;
        else if (stb)
            tcnt <= '0;
        else if (tcnt != TW'(TIMEOUT))
            tcnt <= tcnt + TW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_p      <= 1'b0;
            vs_p      <= 1'b0;
            bl_p      <= 1'b0;
            xcnt      <= '0;
            ycnt      <= '0;
            hcnt      <= '0;
            vcnt      <= '0;
            h_total   <= '0;
            v_total   <= '0;
            frame_bad <= 1'b0;
        end else if (stb) begin
            hs_p <= hs_n;
            vs_p <= vs_n;
            bl_p <= bl_n;

            if (lend)
                xcnt <= '0;
            else if (bl_n)
                xcnt <= sat_inc(xcnt);

            ycnt <= vfall ? '0 : ycnt_l;

            if (hfall) begin
                h_total <= sat_inc(hcnt);
                hcnt    <= '0;
            end else begin
                hcnt <= sat_inc(hcnt);
            end

            if (vfall) begin
                v_total <= vcnt;
                vcnt    <= '0;
            end else if (hfall) begin
                vcnt <= sat_inc(vcnt);
            end

            if (vfall)
                frame_bad <= 1'b0;
            else if (line_bad)
                frame_bad <= 1'b1;
        end
    end

    // Two-stage pixel pipe so pixel_valid trails the first high sample by two clocks.
    logic [1:0] vld_pipe;
    pix_t       pix_s1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            pix_s1   <= '0;
            x        <= '0;
            y        <= '0;
            r        <= '0;
            g        <= '0;
            b        <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], emit};
            if (emit)
                pix_s1 <= '{x: xcnt, y: ycnt, r: in_q[7:0], g: in_q[15:8], b: in_q[23:16]};
            if (vld_pipe[0]) begin
                x <= pix_s1.x;
                y <= pix_s1.y;
                r <= pix_s1.r;
                g <= pix_s1.g;
                b <= pix_s1.b;
            end
        end
    end

    assign pixel_valid = vld_pipe[1];
    assign frame_start = pixel_valid && (x == '0) && (y == '0);

endmodule

// File: tb/tb_vga_capture.sv
// Randomized bench for vga_capture on a scaled-down 16x8 active / 24x12 total
// raster, compared every cycle against a strobe-level model of the receiver.
module tb_vga_capture;
    localparam int HA = 16, VA = 8, HT = 24, VT = 12;
    localparam int HS0 = 18, HS1 = 21, VS0 = 9, VS1 = 10;
    localparam int TO = 255, LF = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [28:0] vga_input_data = '0;
    logic [7:0]  r, g, b;
    logic [9:0]  x, y, h_total, v_total;
    logic        pixel_valid, frame_start, locked, line_error;

    vga_capture #(.H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(LF), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .vga_input_data(vga_input_data),
        .r(r), .g(g), .b(b), .x(x), .y(y),
        .pixel_valid(pixel_valid), .frame_start(frame_start),
        .locked(locked), .line_error(line_error),
        .h_total(h_total), .v_total(v_total)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       lk;
        logic       le;
        logic [9:0] ht;
        logic [9:0] vt;
    } st_t;

    typedef struct packed {
        logic       pv;
        logic       fs;
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } px_t;

    int  cyc = 0;
    int  vectors = 0, miscompares = 0;
    int  n_pv = 0, n_fs = 0, n_le = 0, hits57 = 0;
    bit  run = 1'b0, patt_on = 1'b0;
    st_t st_exp[16];
    px_t px_exp[16];

    always @(posedge clk) cyc <= cyc + 1;

    // Model state: mode 0 = searching, 1 = syncing, 2 = locked.
    int  m_st, m_gc, m_xc, m_yc, m_hc, m_vc, m_ht, m_vt, m_idle;
    bit  m_fok, m_ph, m_pv, m_pb, m_p28;
    px_t m_px;

    function automatic int sat(input int v);
        return (v > 1023) ? 1023 : v;
    endfunction

    function automatic void model_reset();
        m_st = 0; m_gc = 0; m_xc = 0; m_yc = 0; m_hc = 0; m_vc = 0;
        m_ht = 0; m_vt = 0; m_idle = 0;
        m_fok = 1; m_ph = 0; m_pv = 0; m_pb = 0; m_p28 = 0;
        m_px = '0;
        for (int i = 0; i < 16; i++) begin
            st_exp[i] = '0;
            px_exp[i] = '0;
        end
    endfunction

    // One bus word as seen by the receiver; results land 2 (status) and 3 (pixel) clocks later.
    function automatic void model_step(input logic [28:0] w);
        bit  stb, hf, vf, le_, bad, good, err;
        int  st0;
        px_t o;
        o = m_px; o.pv = 0; o.fs = 0;
        err = 0;
        stb = w[28] && !m_p28;
        m_p28 = w[28];
        if (!stb) begin
            m_idle++;
            if (m_idle == TO) m_st = 0;
        end else begin
            m_idle = 0;
            hf  = m_ph && !w[24];
            vf  = m_pv && !w[25];
            le_ = m_pb && !w[26];
            if (w[26] && m_xc < HA && m_yc < VA && m_st == 2) begin
                o.pv = 1; o.fs = (m_xc == 0 && m_yc == 0);
                o.x = 10'(m_xc); o.y = 10'(m_yc);
                o.r = w[7:0]; o.g = w[15:8]; o.b = w[23:16];
                m_px = o;
            end
            bad = le_ && (m_xc != HA);
            if (le_) begin
                if (bad) m_fok = 0;
                m_yc = sat(m_yc + 1);
                m_xc = 0;
            end else if (w[26]) begin
                m_xc = sat(m_xc + 1);
            end
            good = vf && (m_yc == VA) && m_fok;
            if (vf) begin m_yc = 0; m_fok = 1; end
            if (hf) begin m_ht = sat(m_hc + 1); m_hc = 0; end
            else m_hc = sat(m_hc + 1);
            if (vf) begin m_vt = m_vc; m_vc = 0; end
            else if (hf) m_vc = sat(m_vc + 1);
            st0 = m_st;
            if (st0 == 0 && vf) begin
                m_st = 1; m_gc = 0;
            end else if (st0 == 1 && vf) begin
                m_gc = good ? m_gc + 1 : 0;
                if (m_gc == LF) m_st = 2;
            end else if (st0 == 2 && (bad || (vf && !good))) begin
                err = 1; m_st = 0;
            end
            m_ph = w[24]; m_pv = w[25]; m_pb = w[26];
        end
        st_exp[(cyc + 2) % 16] = {(m_st == 2), err, 10'(m_ht), 10'(m_vt)};
        px_exp[(cyc + 3) % 16] = o;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        st_t es, sa;
        px_t ep, pa;
        if (run) begin
            if (!rst) begin
                es = '0; ep = '0;
            end else begin
                es = st_exp[cyc % 16];
                ep = px_exp[cyc % 16];
            end
            sa = {locked, line_error, h_total, v_total};
            pa = {pixel_valid, frame_start, x, y, r, g, b};
            vectors++;
            if (sa !== es || pa !== ep) begin
                miscompares++;
                $display("FAIL cycle %0d outputs: got st=%h px=%h want st=%h px=%h", cyc, sa, pa, es, ep);
            end
            if (pixel_valid) n_pv++;
            if (frame_start) n_fs++;
            if (line_error)  n_le++;
            if (patt_on && pixel_valid && x == 10'd5 && y == 10'd7) begin
                hits57++;
                chk("pixel_5_7_r", int'(r), 5);
                chk("pixel_5_7_g", int'(g), 7);
                chk("pixel_5_7_b", int'(b), 'hA5);
            end
        end
    end

    task automatic put(input logic [28:0] w);
        vga_input_data = w;
        if (rst) model_step(w);
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [28:0] w);
        repeat ($urandom_range(1, 2)) put({1'b0, w[27:0]});
        repeat ($urandom_range(1, 2)) put({1'b1, w[27:0]});
    endtask

    task automatic frame(input bit patt, input int short_y, input int freeze_y, input int rst_y);
        logic [28:0] w;
        logic [7:0]  pr, pg, pb;
        int          act_len;
        for (int yy = 0; yy < VT; yy++) begin
            for (int xx = 0; xx < HT; xx++) begin
                act_len = (yy == short_y) ? HA - 1 : HA;
                if (patt) {pb, pg, pr} = {8'hA5, 8'(yy), 8'(xx)};
                else      {pb, pg, pr} = 24'($urandom);
                w = {1'b0, 1'($urandom_range(0, 1)), (xx < act_len && yy < VA),
                     !(yy >= VS0 && yy <= VS1), !(xx >= HS0 && xx <= HS1), pb, pg, pr};
                if (yy == freeze_y && xx == 5) chk("locked_before_freeze", int'(locked), 1);
                pix(w);
                if (yy == freeze_y && xx == 5) begin
                    repeat (300) put({1'b1, w[27:0]});
                    chk("freeze_unlocks", int'(locked), 0);
                    chk("freeze_no_line_error", n_le, 0);
                end
                if (yy == rst_y && xx == 7) begin
                    rst = 1'b0;
                    model_reset();
                    #1;
                    chk("reset_outputs_zero", int'(|{locked, line_error, pixel_valid, frame_start,
                        h_total, v_total, x, y, r, g, b}), 0);
                    repeat (3) put(w);
                    rst = 1'b1;
                end
                if (yy == rst_y && xx == 10) begin
                    chk("h_total_zero_after_reset", int'(h_total), 0);
                    chk("v_total_zero_after_reset", int'(v_total), 0);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        run = 1'b1;
        @(posedge clk);
        #1;
        repeat (20) put(29'($urandom));
        rst = 1'b1;

        frame(0, -1, -1, -1);
        chk("unlocked_after_first_vfall", int'(locked), 0);
        frame(0, -1, -1, -1);
        frame(0, -1, -1, -1);
        chk("locked_after_third_vfall", int'(locked), 1);
        chk("h_total_24", int'(h_total), HT);
        chk("v_total_12", int'(v_total), VT);

        n_pv = 0; n_fs = 0; patt_on = 1'b1;
        frame(1, -1, -1, -1);
        patt_on = 1'b0;
        chk("pixels_per_frame", n_pv, HA * VA);
        chk("frame_starts_per_frame", n_fs, 1);
        chk("pixel_5_7_seen", hits57, 1);

        n_pv = 0; n_le = 0;
        frame(0, 3, -1, -1);
        chk("short_line_error_pulses", n_le, 1);
        chk("short_line_unlocked", int'(locked), 0);
        chk("pixels_before_short_line_error", n_pv, 3 * HA + HA - 1);

        frame(0, -1, -1, -1);
        frame(0, -1, -1, -1);
        chk("relock_after_short_line", int'(locked), 1);

        n_le = 0;
        frame(0, -1, 2, -1);
        chk("syncing_after_freeze", int'(locked), 0);
        frame(0, -1, -1, -1);
        frame(0, -1, -1, -1);
        chk("relock_after_freeze", int'(locked), 1);

        frame(0, -1, -1, 4);
        chk("unlocked_after_reset", int'(locked), 0);
        frame(0, -1, -1, -1);
        frame(0, -1, -1, -1);
        chk("relock_after_reset", int'(locked), 1);
        frame(0, -1, -1, -1);

        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
